// File: rtl/vc_rr_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : vc_rr_tx_scheduler
// Brief   : Round-robin transmit scheduler. Keeps a ring of active queues fed
//           by doorbells, issues one tagged tx request per turn, and re-arms
//           or retires each queue from the returned status length.
// Revision: 1.0 - initial release
// ============================================================================
module vc_rr_tx_scheduler #(
  parameter int QUEUE_INDEX_WIDTH = 6,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int LEN_WIDTH         = 16,
  parameter int MAX_OUTSTANDING   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_doorbell_queue,
  input  logic                         s_axis_doorbell_valid,
  output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_tx_req_queue,
  output logic [REQ_TAG_WIDTH-1:0]     m_axis_tx_req_tag,
  output logic                         m_axis_tx_req_valid,
  input  logic                         m_axis_tx_req_ready,
  input  logic [LEN_WIDTH-1:0]         s_axis_tx_status_len,
  input  logic [REQ_TAG_WIDTH-1:0]     s_axis_tx_status_tag,
  input  logic                         s_axis_tx_status_valid,
  output logic [QUEUE_INDEX_WIDTH:0]   active_count,
  output logic [REQ_TAG_WIDTH:0]       outstanding_count,
  output logic                         err_bad_tag
);

  localparam int QUEUE_COUNT = 2 ** QUEUE_INDEX_WIDTH;
  localparam int TIW         = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  // Per-queue bookkeeping and the ring of queues waiting for a turn
  logic [QUEUE_COUNT-1:0]       r_active;
  logic [QUEUE_COUNT-1:0]       r_pending;
  logic [QUEUE_INDEX_WIDTH-1:0] r_ring [QUEUE_COUNT];
  logic [QUEUE_INDEX_WIDTH-1:0] r_wr_ptr;
  logic [QUEUE_INDEX_WIDTH-1:0] r_rd_ptr;
  logic [QUEUE_INDEX_WIDTH:0]   r_ring_cnt;

  // Tag table: busy flag plus the queue each tag was issued for
  logic [MAX_OUTSTANDING-1:0]   r_tag_busy;
  logic [QUEUE_INDEX_WIDTH-1:0] r_tag_queue [MAX_OUTSTANDING];

  logic [0:0]                   r_state;
  logic [QUEUE_INDEX_WIDTH-1:0] r_req_queue;
  logic [REQ_TAG_WIDTH-1:0]     r_req_tag;
  logic                         r_req_valid;
  logic [QUEUE_INDEX_WIDTH:0]   r_active_count;
  logic [REQ_TAG_WIDTH:0]       r_outstanding_count;
  logic                         r_err_bad_tag;

  logic                         w_st_hit;
  logic [QUEUE_INDEX_WIDTH-1:0] w_st_queue;
  logic [MAX_OUTSTANDING-1:0]   w_st_free_mask;
  logic                         w_st_push;
  logic                         w_st_retire;
  logic                         w_db_push;
  logic [QUEUE_COUNT-1:0]       w_active_nx;
  logic [QUEUE_COUNT-1:0]       w_pending_nx;
  logic                         w_alloc_ok;
  logic [TIW-1:0]               w_alloc_slot;
  logic [MAX_OUTSTANDING-1:0]   w_alloc_mask;
  logic                         w_issue;
  logic [QUEUE_INDEX_WIDTH-1:0] w_head;

  assign w_head = r_ring[r_rd_ptr];

  // Match the returned tag against allocated table entries
  always_comb begin
    w_st_hit       = 1'b0;
    w_st_queue     = '0;
    w_st_free_mask = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (s_axis_tx_status_valid && r_tag_busy[i] &&
          ({1'b0, s_axis_tx_status_tag} == (REQ_TAG_WIDTH+1)'(i))) begin
        w_st_hit          = 1'b1;
        w_st_queue        = r_tag_queue[i];
        w_st_free_mask[i] = 1'b1;
      end
    end
  end

  // Apply status then doorbell to the active/pending bits; doorbell sees status result
  always_comb begin
    w_active_nx  = r_active;
    w_pending_nx = r_pending;
    w_st_push    = 1'b0;
    w_st_retire  = 1'b0;
    w_db_push    = 1'b0;
    if (w_st_hit) begin
      if ((s_axis_tx_status_len != '0) || r_pending[w_st_queue]) begin
        w_st_push = 1'b1;
      end else begin
        w_st_retire             = 1'b1;
        w_active_nx[w_st_queue] = 1'b0;
      end
      w_pending_nx[w_st_queue] = 1'b0;
    end
    if (s_axis_doorbell_valid) begin
      if (!w_active_nx[s_axis_doorbell_queue]) begin
        w_active_nx[s_axis_doorbell_queue] = 1'b1;
        w_db_push                          = 1'b1;
      end else begin
        w_pending_nx[s_axis_doorbell_queue] = 1'b1;
      end
    end
  end

  // Pick the lowest free tag and decide whether a new request starts this cycle
  always_comb begin
    w_alloc_ok   = 1'b0;
    w_alloc_slot = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!r_tag_busy[i]) begin
        w_alloc_ok   = 1'b1;
        w_alloc_slot = TIW'(i);
      end
    end
    w_issue = (r_state == S_IDLE) && enable && (r_ring_cnt != '0) &&
              w_alloc_ok && !r_req_valid;
    w_alloc_mask = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      w_alloc_mask[i] = w_issue && (TIW'(i) == w_alloc_slot);
    end
  end

  // Ring and tag-table payload storage; validity is tracked by pointers and busy bits
  always_ff @(posedge clk) begin
    if (w_st_push) begin
      r_ring[r_wr_ptr] <= w_st_queue;
    end
    if (w_db_push) begin
      r_ring[r_wr_ptr + QUEUE_INDEX_WIDTH'(w_st_push)] <= s_axis_doorbell_queue;
    end
    if (w_issue) begin
      r_tag_queue[w_alloc_slot] <= w_head;
    end
  end

  // Control state, pointers, counters and the issue FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active            <= '0;
      r_pending           <= '0;
      r_wr_ptr            <= '0;
      r_rd_ptr            <= '0;
      r_ring_cnt          <= '0;
      r_tag_busy          <= '0;
      r_state             <= S_IDLE;
      r_req_queue         <= '0;
      r_req_tag           <= '0;
      r_req_valid         <= 1'b0;
      r_active_count      <= '0;
      r_outstanding_count <= '0;
      r_err_bad_tag       <= 1'b0;
    end else begin
      r_active   <= w_active_nx;
      r_pending  <= w_pending_nx;
      r_wr_ptr   <= r_wr_ptr + QUEUE_INDEX_WIDTH'(w_st_push) + QUEUE_INDEX_WIDTH'(w_db_push);
      r_rd_ptr   <= r_rd_ptr + QUEUE_INDEX_WIDTH'(w_issue);
      r_ring_cnt <= r_ring_cnt + (QUEUE_INDEX_WIDTH+1)'(w_st_push)
                               + (QUEUE_INDEX_WIDTH+1)'(w_db_push)
                               - (QUEUE_INDEX_WIDTH+1)'(w_issue);
      r_tag_busy <= (r_tag_busy & ~w_st_free_mask) | w_alloc_mask;
      r_active_count <= r_active_count + (QUEUE_INDEX_WIDTH+1)'(w_db_push)
                                       - (QUEUE_INDEX_WIDTH+1)'(w_st_retire);
      r_outstanding_count <= r_outstanding_count + (REQ_TAG_WIDTH+1)'(w_issue)
                                                 - (REQ_TAG_WIDTH+1)'(w_st_hit);
      if (s_axis_tx_status_valid && !w_st_hit) begin
        r_err_bad_tag <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
            r_req_queue <= w_head;
            r_req_tag   <= REQ_TAG_WIDTH'(w_alloc_slot);
          end
        end
        S_REQ: begin
          if (r_req_valid && m_axis_tx_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tx_req_queue = r_req_queue;
  assign m_axis_tx_req_tag   = r_req_tag;
  assign m_axis_tx_req_valid = r_req_valid;
  assign active_count        = r_active_count;
  assign outstanding_count   = r_outstanding_count;
  assign err_bad_tag         = r_err_bad_tag;

endmodule
`default_nettype wire

// File: tb/tb_vc_rr_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_vc_rr_tx_scheduler
// Brief   : Self-checking bench for vc_rr_tx_scheduler: directed scenarios
//           followed by random traffic, compared against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vc_rr_tx_scheduler;

  localparam int QIW  = 6;
  localparam int TAGW = 8;
  localparam int LENW = 16;
  localparam int MO   = 4;
  localparam int QC   = 2 ** QIW;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [QIW-1:0]  db_queue;
  logic            db_valid;
  logic [QIW-1:0]  req_queue;
  logic [TAGW-1:0] req_tag;
  logic            req_valid;
  logic            req_ready;
  logic [LENW-1:0] st_len;
  logic [TAGW-1:0] st_tag;
  logic            st_valid;
  logic [QIW:0]    active_count;
  logic [TAGW:0]   outstanding_count;
  logic            err_bad_tag;

  always #5 clk = ~clk;

  vc_rr_tx_scheduler #(
    .QUEUE_INDEX_WIDTH(QIW),
    .REQ_TAG_WIDTH    (TAGW),
    .LEN_WIDTH        (LENW),
    .MAX_OUTSTANDING  (MO)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .s_axis_doorbell_queue (db_queue),
    .s_axis_doorbell_valid (db_valid),
    .m_axis_tx_req_queue   (req_queue),
    .m_axis_tx_req_tag     (req_tag),
    .m_axis_tx_req_valid   (req_valid),
    .m_axis_tx_req_ready   (req_ready),
    .s_axis_tx_status_len  (st_len),
    .s_axis_tx_status_tag  (st_tag),
    .s_axis_tx_status_valid(st_valid),
    .active_count          (active_count),
    .outstanding_count     (outstanding_count),
    .err_bad_tag           (err_bad_tag)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: sets of active/pending queues, a plain FIFO ring, tag table
  bit m_active [QC];
  bit m_pending[QC];
  int m_ring[$];
  bit m_busy[MO];
  int m_tq[MO];
  bit m_valid;
  int m_q;
  int m_tag;
  bit m_err;
  int done_tags[$];
  int seen_q[$];
  int seen_t[$];

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  function automatic int n_active();
    int n = 0;
    for (int i = 0; i < QC; i++) n += int'(m_active[i]);
    return n;
  endfunction

  function automatic int n_busy();
    int n = 0;
    for (int i = 0; i < MO; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic int count_seen(int q);
    int n = 0;
    foreach (seen_q[i]) if (seen_q[i] == q) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < QC; i++) begin
      m_active[i]  = 1'b0;
      m_pending[i] = 1'b0;
    end
    for (int i = 0; i < MO; i++) begin
      m_busy[i] = 1'b0;
      m_tq[i]   = 0;
    end
    m_ring.delete();
    done_tags.delete();
    m_valid = 1'b0;
    m_q     = 0;
    m_tag   = 0;
    m_err   = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs
  task automatic step(bit r, bit en, bit dv, int dq, bit sv, int st, int sl, bit rdy);
    int  ntag;
    bit  iss;
    int  q;
    rst       = r;
    enable    = en;
    db_valid  = dv;
    db_queue  = QIW'(dq);
    st_valid  = sv;
    st_tag    = TAGW'(st);
    st_len    = LENW'(sl);
    req_ready = rdy;
    if (!r && req_valid && rdy) begin
      seen_q.push_back(int'(req_queue));
      seen_t.push_back(int'(req_tag));
    end
    if (r) begin
      model_reset();
    end else begin
      ntag = -1;
      for (int i = MO - 1; i >= 0; i--) if (!m_busy[i]) ntag = i;
      iss = en && !m_valid && (m_ring.size() > 0) && (ntag >= 0);
      if (m_valid && rdy) begin
        m_valid = 1'b0;
        done_tags.push_back(m_tag);
      end
      if (sv) begin
        if (st < MO && m_busy[st]) begin
          q         = m_tq[st];
          m_busy[st] = 1'b0;
          if (sl > 0 || m_pending[q]) begin
            m_pending[q] = 1'b0;
            m_ring.push_back(q);
          end else begin
            m_active[q] = 1'b0;
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (dv) begin
        if (!m_active[dq]) begin
          m_active[dq] = 1'b1;
          m_ring.push_back(dq);
        end else begin
          m_pending[dq] = 1'b1;
        end
      end
      if (iss) begin
        q            = m_ring.pop_front();
        m_busy[ntag] = 1'b1;
        m_tq[ntag]   = q;
        m_valid      = 1'b1;
        m_q          = q;
        m_tag        = ntag;
      end
    end
    @(posedge clk);
    #1;
    chk("valid", 32'(req_valid), 32'(m_valid));
    if (m_valid) begin
      chk("req_queue", 32'(req_queue), 32'(m_q));
      chk("req_tag", 32'(req_tag), 32'(m_tag));
    end
    chk("active_count", 32'(active_count), 32'(n_active()));
    chk("outstanding_count", 32'(outstanding_count), 32'(n_busy()));
    chk("err_bad_tag", 32'(err_bad_tag), 32'(m_err));
  endtask

  // Idle cycles; optionally return one completed tag per cycle with a fixed length
  task automatic idle(int n, bit en, bit rdy, bit ret, int len);
    int t;
    for (int k = 0; k < n; k++) begin
      if (ret && done_tags.size() > 0) begin
        t = done_tags.pop_front();
        step(1'b0, en, 1'b0, 0, 1'b1, t, len, rdy);
      end else begin
        step(1'b0, en, 1'b0, 0, 1'b0, 0, 0, rdy);
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    seen_q.delete();
    seen_t.delete();
  endtask

  initial begin
    int exp_seq[6];
    int t;
    int idx;
    int len;
    bit en;
    bit rdy;
    bit dv;
    int dq;

    exp_seq = '{3, 5, 9, 3, 5, 9};
    model_reset();

    // Reset state
    do_reset();
    chk("rst_valid", 32'(req_valid), 32'd0);
    chk("rst_active", 32'(active_count), 32'd0);

    // Three queues rotate with every status reporting a sent packet
    step(1'b0, 1'b1, 1'b1, 3, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 5, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 9, 1'b0, 0, 0, 1'b1);
    idle(30, 1'b1, 1'b1, 1'b1, 64);
    chk("rr_active3", 32'(active_count), 32'd3);
    chk("rr_enough", 32'(seen_q.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < seen_q.size(); i++) chk("rr_order", 32'(seen_q[i]), 32'(exp_seq[i]));
    if (seen_t.size() >= 2) begin
      chk("rr_tag0", 32'(seen_t[0]), 32'd0);
      chk("rr_tag1", 32'(seen_t[1]), 32'd1);
    end

    // Blocked status retires a queue; a fresh doorbell revives it
    do_reset();
    step(1'b0, 1'b1, 1'b1, 7, 1'b0, 0, 0, 1'b1);
    idle(12, 1'b1, 1'b1, 1'b1, 0);
    chk("retire_active", 32'(active_count), 32'd0);
    chk("retire_valid", 32'(req_valid), 32'd0);
    chk("retire_once", 32'(count_seen(7)), 32'd1);
    step(1'b0, 1'b1, 1'b1, 7, 1'b0, 0, 0, 1'b1);
    idle(12, 1'b1, 1'b1, 1'b1, 0);
    chk("revive_twice", 32'(count_seen(7)), 32'd2);

    // Doorbell while in flight sets pending; blocked status then re-pushes once
    do_reset();
    step(1'b0, 1'b1, 1'b1, 2, 1'b0, 0, 0, 1'b1);
    idle(4, 1'b1, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 2, 1'b0, 0, 0, 1'b1);
    idle(16, 1'b1, 1'b1, 1'b1, 0);
    chk("pending_reissue", 32'(count_seen(2)), 32'd2);
    chk("pending_retired", 32'(active_count), 32'd0);

    // Tag exhaustion: four requests, then one freed tag is reused
    do_reset();
    for (int q = 10; q < 16; q++) step(1'b0, 1'b1, 1'b1, q, 1'b0, 0, 0, 1'b1);
    idle(16, 1'b1, 1'b1, 1'b0, 0);
    chk("exhaust_n", 32'(seen_q.size()), 32'd4);
    chk("exhaust_out", 32'(outstanding_count), 32'd4);
    chk("exhaust_valid", 32'(req_valid), 32'd0);
    idx = -1;
    foreach (done_tags[i]) if (done_tags[i] == 1) idx = i;
    if (idx >= 0) done_tags.delete(idx);
    step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1, 64, 1'b1);
    idle(4, 1'b1, 1'b1, 1'b0, 0);
    chk("reuse_n", 32'(seen_q.size()), 32'd5);
    if (seen_t.size() >= 5) chk("reuse_tag", 32'(seen_t[4]), 32'd1);

    // Same-cycle retire and doorbell of one queue: it stays in the ring once
    do_reset();
    step(1'b0, 1'b1, 1'b1, 4, 1'b0, 0, 0, 1'b1);
    idle(4, 1'b1, 1'b1, 1'b0, 0);
    if (done_tags.size() > 0) begin
      t = done_tags.pop_front();
      step(1'b0, 1'b1, 1'b1, 4, 1'b1, t, 0, 1'b1);
    end
    chk("same_active", 32'(active_count), 32'd1);
    idle(16, 1'b1, 1'b1, 1'b1, 0);
    chk("same_once", 32'(count_seen(4)), 32'd2);
    chk("same_retired", 32'(active_count), 32'd0);

    // Unallocated tag flags an error; reset mid-request clears everything
    do_reset();
    step(1'b0, 1'b1, 1'b0, 0, 1'b1, 200, 5, 1'b1);
    chk("badtag_err", 32'(err_bad_tag), 32'd1);
    chk("badtag_active", 32'(active_count), 32'd0);
    step(1'b0, 1'b1, 1'b1, 6, 1'b0, 0, 0, 1'b0);
    idle(3, 1'b1, 1'b0, 1'b0, 0);
    chk("midreq_valid", 32'(req_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
    chk("enable_low_holds", 32'(req_valid), 32'd1);
    do_reset();
    chk("rst_mid_valid", 32'(req_valid), 32'd0);
    chk("rst_mid_out", 32'(outstanding_count), 32'd0);
    chk("rst_mid_err", 32'(err_bad_tag), 32'd0);

    // Random traffic against the model
    for (int k = 0; k < 800; k++) begin
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      dv  = ($urandom_range(0, 9) < 3);
      dq  = int'($urandom_range(0, 15));
      if (done_tags.size() > 0 && $urandom_range(0, 9) < 4) begin
        idx = int'($urandom_range(0, done_tags.size() - 1));
        t   = done_tags[idx];
        done_tags.delete(idx);
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 1500));
        step(1'b0, en, dv, dq, 1'b1, t, len, rdy);
      end else if ($urandom_range(0, 99) < 3) begin
        t = int'($urandom_range(MO, 255));
        step(1'b0, en, dv, dq, 1'b1, t, 0, rdy);
      end else begin
        step(1'b0, en, dv, dq, 1'b0, 0, 0, rdy);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
